// File: rtl/router_in_arbiter.sv
// rtl/router_in_arbiter.sv - two-source round-robin packet arbiter in front of the router input port
// Optional watchdog abort: define ROUTER_ARB_TIMEOUT_EN.
module router_in_arbiter (
   input  logic       clk,
   input  logic       reset,
   input  logic       pkt_valid_0,
   input  logic       pkt_valid_1,
   input  logic [7:0] data_in_0,
   input  logic [7:0] data_in_1,
   input  logic       par_valid_0,
   input  logic       par_valid_1,
   input  logic       busy,
   output logic       ready_0,
   output logic       ready_1,
   output logic       pkt_valid,
   output logic [7:0] data_out,
   output logic [1:0] gnt,
   output logic       proto_err,
   output logic       timeout
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HEADER  = 3'd1,
      S_PAYLOAD = 3'd2,
      S_PARITY  = 3'd3,
      S_DROP    = 3'd4,
      S_GAP     = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        gnt_src;
   logic        rr_ptr;
   logic        pick;
   logic        any_req;
   logic [5:0]  count;
   logic [7:0]  data_q;
   logic        src_pv;
   logic        src_par;
   logic [7:0]  src_data;
   logic        xfer;
   logic        consume;
   logic        fwd;
   logic        drive;
   logic        err;
   logic        wd_fire;

   assign src_pv   = gnt_src ? pkt_valid_1 : pkt_valid_0;
   assign src_par  = gnt_src ? par_valid_1 : par_valid_0;
   assign src_data = gnt_src ? data_in_1   : data_in_0;
   assign any_req  = pkt_valid_0 | pkt_valid_1;
   // rr_ptr names the source that wins the next tie
   assign pick     = (pkt_valid_0 & pkt_valid_1) ? rr_ptr : pkt_valid_1;

`ifdef ROUTER_ARB_TIMEOUT_EN
   logic [4:0] wd_cnt;
   logic       wd_active;

   assign wd_active = (state == S_HEADER) || (state == S_PAYLOAD) || (state == S_PARITY);

   always_ff @(posedge clk) begin
      if (reset || xfer || !wd_active || (state_nxt != state)) begin
         wd_cnt <= 5'd0;
      end else begin
         wd_cnt <= wd_cnt + 5'd1;
      end
   end

   // fires on the 30th consecutive stalled cycle
   assign wd_fire = !reset && wd_active && !xfer && !err && (wd_cnt == 5'd29);
`else
   assign wd_fire = 1'b0;
`endif

   assign timeout = wd_fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (any_req) state_nxt = S_HEADER;
         end
         S_HEADER: begin
            if (err) begin
               state_nxt = S_GAP;
            end else if (xfer) begin
               if (src_data[1:0] == 2'b11)      state_nxt = S_DROP;
               else if (src_data[7:2] == 6'd0)  state_nxt = S_PARITY;
               else                             state_nxt = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (err)                           state_nxt = S_GAP;
            else if (xfer && count == 6'd1)    state_nxt = S_PARITY;
         end
         S_PARITY: begin
            if (xfer) state_nxt = S_GAP;
         end
         S_DROP: begin
            if (consume && src_par) state_nxt = S_GAP;
         end
         S_GAP:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (wd_fire) state_nxt = S_GAP;
   end

   // busy gates every byte movement, including draining in DROP
   always_comb begin
      xfer    = 1'b0;
      consume = 1'b0;
      fwd     = 1'b0;
      err     = 1'b0;
      if (!reset && !busy) begin
         case (state)
            S_HEADER: begin
               if (src_par) begin
                  err = 1'b1;
               end else if (src_pv) begin
                  xfer = 1'b1;
                  fwd  = (src_data[1:0] != 2'b11);
               end
            end
            S_PAYLOAD: begin
               if (!src_pv || src_par) begin
                  err = 1'b1;
               end else begin
                  xfer = 1'b1;
                  fwd  = 1'b1;
               end
            end
            S_PARITY: xfer    = src_par;
            S_DROP:   consume = src_pv | src_par;
            default: ;
         endcase
      end
      drive     = fwd | (xfer && (state == S_PARITY));
      ready_0   = (xfer | consume) & ~gnt_src;
      ready_1   = (xfer | consume) & gnt_src;
      pkt_valid = fwd;
      data_out  = drive ? src_data : data_q;
      proto_err = err;
      gnt       = 2'b00;
      if ((state == S_HEADER) || (state == S_PAYLOAD) || (state == S_PARITY) || (state == S_DROP)) begin
         gnt = gnt_src ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gnt_src <= 1'b0;
         rr_ptr  <= 1'b0;
         count   <= 6'd0;
         data_q  <= 8'h00;
      end else begin
         if (state == S_IDLE && any_req) begin
            gnt_src <= pick;
            rr_ptr  <= ~pick;
         end
         if (drive) data_q <= src_data;
         if (state == S_HEADER && xfer) begin
            count <= src_data[7:2];
         end else if (state == S_PAYLOAD && xfer) begin
            count <= count - 6'd1;
         end
      end
   end

endmodule
